// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch (i_*), load/store (d_*) and memory (m_*) signals around
// the shared memory port. The arbiter takes the slave view; the core datapath
// plus memory (or a bench) take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    // load/store requester
    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // memory port
    logic              m_req;
    logic              m_we;
    logic [BE_W-1:0]   m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_gnt;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch
// (I) and load/store (D). D wins by default; after STARVE_LIMIT consecutive D
// grants with a fetch waiting, the fetch is forced through.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

    state_t            state, state_nxt;
    owner_t            owner;
    logic [3:0]        starve_cnt;
    logic              grant_i, grant_d;

    logic              m_we_q;
    logic [BE_W-1:0]   m_be_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state and grant selection; grants are masked by rst_n so they
    // read 0 while reset is held even though the FSM already sits in IDLE
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst_n) begin
                    if (bus.d_req && !(bus.i_req && starve_cnt == LIMIT)) grant_d = 1'b1;
                    else if (bus.i_req)                                  grant_i = 1'b1;
                end
                if (grant_i || grant_d) state_nxt = REQ;
            end
            REQ:     if (bus.m_gnt)    state_nxt = RESP;
            RESP:    if (bus.m_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // capture the winner's payload and ownership at the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            owner     <= OWN_I;
        end else if (grant_d) begin
            m_we_q    <= bus.d_we;
            m_be_q    <= bus.d_be;
            m_addr_q  <= bus.d_addr;
            m_wdata_q <= bus.d_wdata;
            owner     <= OWN_D;
        end else if (grant_i) begin
            m_we_q    <= 1'b0;
            m_be_q    <= '1;
            m_addr_q  <= bus.i_addr;
            m_wdata_q <= '0;
            owner     <= OWN_I;
        end
    end

    // count D wins that overtook a waiting fetch; any other grant clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!bus.i_req)                starve_cnt <= '0;
            else if (starve_cnt != LIMIT)  starve_cnt <= starve_cnt + 4'd1;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end
    end

    assign bus.i_gnt    = grant_i;
    assign bus.d_gnt    = grant_d;
    assign bus.m_req    = (state == REQ);
    assign bus.m_we     = m_we_q;
    assign bus.m_be     = m_be_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    // only the valid strobe is steered; data goes to both requesters
    assign bus.i_rvalid = (state == RESP) && bus.m_rvalid && (owner == OWN_I);
    assign bus.d_rvalid = (state == RESP) && bus.m_rvalid && (owner == OWN_D);
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model:
// an outstanding-transaction flag, an accepted flag, the owner, the expected
// payload and a run length of D wins past a waiting fetch.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;

    // model state
    bit          busy, acc, own_d;
    int          streak;
    bit          e_we;
    logic [BW-1:0] e_be;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit          ig_s, dg_s;
    bit          did_rst;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, ".m_req"},    64'(bus.m_req),    64'd0);
        chk({tag, ".m_we"},     64'(bus.m_we),     64'd0);
        chk({tag, ".m_be"},     64'(bus.m_be),     64'd0);
        chk({tag, ".m_addr"},   64'(bus.m_addr),   64'd0);
        chk({tag, ".m_wdata"},  64'(bus.m_wdata),  64'd0);
        chk({tag, ".i_gnt"},    64'(bus.i_gnt),    64'd0);
        chk({tag, ".d_gnt"},    64'(bus.d_gnt),    64'd0);
        chk({tag, ".i_rvalid"}, 64'(bus.i_rvalid), 64'd0);
        chk({tag, ".d_rvalid"}, 64'(bus.d_rvalid), 64'd0);
    endtask

    // requesters hold until they see their grant; memory handshakes are random
    // every cycle, so stray m_gnt / m_rvalid outside their phase occur often
    task automatic drive(input int pi, input int pd, input int pg, input int pv);
        if (ig_s || !bus.i_req) begin
            bus.i_req  = ($urandom_range(99) < pi);
            bus.i_addr = $urandom;
        end
        if (dg_s || !bus.d_req) begin
            bus.d_req   = ($urandom_range(99) < pd);
            bus.d_we    = 1'($urandom_range(1));
            bus.d_be    = BW'($urandom_range((1 << BW) - 1));
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
        end
        bus.m_gnt    = ($urandom_range(99) < pg);
        bus.m_rvalid = ($urandom_range(99) < pv);
        bus.m_rdata  = $urandom;
    endtask

    // compare this cycle's outputs with the model, then advance the model
    task automatic sample();
        bit free, wi, wd;
        free = !busy;
        wd   = free && bus.d_req && !(bus.i_req && streak == LIM);
        wi   = free && !wd && bus.i_req;
        chk("i_gnt",    64'(bus.i_gnt),    64'(wi));
        chk("d_gnt",    64'(bus.d_gnt),    64'(wd));
        chk("m_req",    64'(bus.m_req),    64'(busy && !acc));
        chk("i_rvalid", 64'(bus.i_rvalid), 64'(busy && acc && bus.m_rvalid && !own_d));
        chk("d_rvalid", 64'(bus.d_rvalid), 64'(busy && acc && bus.m_rvalid && own_d));
        chk("i_rdata",  64'(bus.i_rdata),  64'(bus.m_rdata));
        chk("d_rdata",  64'(bus.d_rdata),  64'(bus.m_rdata));
        if (busy && !acc) begin
            chk("m_we",    64'(bus.m_we),    64'(e_we));
            chk("m_be",    64'(bus.m_be),    64'(e_be));
            chk("m_addr",  64'(bus.m_addr),  64'(e_addr));
            chk("m_wdata", 64'(bus.m_wdata), 64'(e_wdata));
        end
        ig_s = bus.i_gnt;
        dg_s = bus.d_gnt;
        if (wd || wi) begin
            busy  = 1'b1;
            acc   = 1'b0;
            own_d = wd;
            if (wd) begin
                e_we    = bus.d_we;
                e_be    = bus.d_be;
                e_addr  = bus.d_addr;
                e_wdata = bus.d_wdata;
                streak  = bus.i_req ? ((streak < LIM) ? streak + 1 : LIM) : 0;
            end else begin
                e_we    = 1'b0;
                e_be    = '1;
                e_addr  = bus.i_addr;
                e_wdata = '0;
                streak  = 0;
            end
        end else if (busy && !acc) begin
            if (bus.m_gnt) acc = 1'b1;
        end else if (busy && bus.m_rvalid) begin
            busy = 1'b0;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_be    = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.m_gnt   = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata = '0;
        busy = 0; acc = 0; own_d = 0; streak = 0;
        e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
        ig_s = 0; dg_s = 0; did_rst = 0;

        #12;
        reset_chk("por");
        #1 rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (!did_rst && c > 1200 && busy && acc) begin
                // abandon a transaction waiting for its response
                rst_n        = 1'b0;
                bus.i_req    = 1'b1;
                bus.d_req    = 1'b1;
                bus.m_gnt    = 1'b1;
                bus.m_rvalid = 1'b1;
                #1 reset_chk("mid");
                #1 rst_n = 1'b1;
                busy = 0; acc = 0; streak = 0;
                ig_s = 0; dg_s = 0;
                bus.d_req    = 1'b0;
                bus.i_addr   = $urandom;
                bus.m_rvalid = 1'b0;
                did_rst = 1'b1;
            end else if (c < 100) begin
                // both requesters saturated: exercises the forced fetch slot
                drive(100, 100, 70, 70);
            end else begin
                drive(40, 50, 50, 50);
            end
            @(negedge clk);
            sample();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
